mac_sched_ctrl: RTL and testbench
=================================

MAC_SCHED_CTRL -- requirements
Module: mac_sched_ctrl

Interface
REQ-001 Parameter PIPE_LAT, default 12: cycles from mac_data_valid_o to the product reaching the MAC accumulator.
REQ-002 Parameter SCALE_LAT, default 3: cycles from accumulator register to clipped output register.
REQ-003 Parameter ACC_W, default 8: width of the accumulate-count configuration.
REQ-004 Parameter PIX_W, default 16: width of the output-pixel count.
REQ-005 Ports, in order:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  layer start pulse.
- cfg_acc_num_i  in  ACC_W  beats per output pixel.
- cfg_pix_num_i  in  PIX_W  output pixels per layer.
- cfg_scale_i  in  16  right-shift amount.
- busy_o  out  1  layer in progress.
- done_o  out  1  one-cycle completion pulse.
- act_valid_i  in  1  activation beat available.
- act_ready_o  out  1  controller accepts beat.
- wgt_addr_o  out  ACC_W  weight-buffer read address (beat index).
- wgt_rd_o  out  1  weight-buffer read enable.
- mac_data_valid_o  out  1  beat valid into MAC.
- mac_weight_valid_o  out  1  weight valid into MAC.
- mac_acc_en_o  out  1  accumulator enable.
- mac_adder_rst_o  out  1  accumulator load (first beat).
- mac_scale_o  out  16  latched scale.
- mac_acc_num_o  out  8  latched accumulate count.
- out_valid_o  out  1  MAC output word valid.

Function
REQ-006 The FSM SHALL have states IDLE, RUN, DRAIN, DONE.
REQ-007 IDLE->RUN on start_i=1: cfg_* latched; beat_cnt=0; pix_cnt=0.
REQ-008 start_i SHALL be ignored outside IDLE.
REQ-009 cfg_acc_num_i=0 SHALL be treated as 1.
REQ-010 cfg_pix_num_i=0 SHALL go IDLE->DONE directly, issuing no beats.
REQ-011 act_ready_o SHALL be 1 only in RUN; a beat is accepted when act_valid_i and act_ready_o are both 1.
REQ-012 On an accepted beat: wgt_rd_o=1 and wgt_addr_o=beat_cnt in the same cycle.
REQ-013 mac_data_valid_o and mac_weight_valid_o SHALL assert exactly one cycle after the accepted beat, matching the 1-cycle weight read.
REQ-014 beat_cnt SHALL wrap from acc_num-1 to 0 and increment pix_cnt on the wrap.
REQ-015 Acceptance of beat acc_num-1 of pixel pix_num-1 SHALL move RUN->DRAIN.
REQ-016 act_valid_i=0 in RUN SHALL insert a bubble: no counter advance, and the bubble's tag carries valid=0.
REQ-017 Each beat's tag {valid, first, last} SHALL be delayed PIPE_LAT cycles after mac_data_valid_o; then:
- mac_acc_en_o = valid.
- mac_adder_rst_o = valid & first.
REQ-018 out_valid_o SHALL equal the delayed valid & last, a further 1+SCALE_LAT cycles later.
REQ-019 Total latency SHALL be exactly PIPE_LAT+SCALE_LAT+2 cycles from last-beat acceptance to out_valid_o (17 at defaults).
REQ-020 DRAIN SHALL exit to DONE once the tag pipeline holds no valid tag.
REQ-021 DONE SHALL pulse done_o for one cycle, then return to IDLE.
REQ-022 busy_o SHALL be 1 in RUN, DRAIN and DONE.
REQ-023 mac_scale_o and mac_acc_num_o SHALL hold the latched values until the next accepted start.

Reset
REQ-024 rst=1 SHALL asynchronously force:
- FSM to IDLE.
- All counters and tag stages to 0.
- Every output to 0, including mac_scale_o and mac_acc_num_o.
REQ-025 Reset mid-layer SHALL discard in-flight tags: no out_valid_o or done_o after release until a new start.

Configuration
REQ-026 With MAC_SCHED_PERF_CNT_EN defined, the block SHALL add outputs:
- perf_busy_cyc_o[31:0]: counts cycles with busy_o=1.
- perf_stall_cyc_o[31:0]: counts RUN cycles with act_valid_i=0.
Both SHALL clear on an accepted start and saturate at all-ones.
REQ-027 Without MAC_SCHED_PERF_CNT_EN, these ports and counters SHALL not exist.

Structure
REQ-028 Package cnn_ctrl_pkg SHALL hold the FSM state typedef, the tag struct, and the default PIPE_LAT/SCALE_LAT constants.
REQ-029 The tag delay line SHALL be sub-module mac_ctrl_tag_pipe, parameterised by depth.

Verification
REQ-030 acc=4, pix=2, act_valid_i always 1:
- 8 beats on consecutive cycles; wgt_addr_o = 0,1,2,3,0,1,2,3.
- mac_adder_rst_o 13 cycles after beats 0 and 4.
- out_valid_o 17 cycles after beats 3 and 7.
- done_o once.
REQ-031 acc=3, pix=1, act_valid_i low 2 cycles after beat 1:
- No counter advance during the bubble.
- mac_acc_en_o low for 2 cycles mid-window.
- out_valid_o 17 cycles after beat 2.
REQ-032 cfg_pix_num_i=0: done_o 2 cycles after start_i; no act_ready_o, no out_valid_o.
REQ-033 cfg_acc_num_i=0, pix=3: every beat is both first and last; three out_valid_o pulses.
REQ-034 rst pulsed during DRAIN: all outputs 0 immediately; no out_valid_o or done_o afterwards; a new start runs normally.
REQ-035 start_i during RUN: ignored, with no change to cfg latches or counters.

Source files
------------

// File: rtl/cnn_ctrl_pkg.sv
// Shared types and default latencies for the MAC scheduling controller.
package cnn_ctrl_pkg;

  localparam int PIPE_LAT_DEF  = 12;
  localparam int SCALE_LAT_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } sched_state_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } mac_tag_t;

  localparam int TAG_W = $bits(mac_tag_t);

endpackage

// File: rtl/mac_ctrl_tag_pipe.sv
// Fixed-depth delay line for per-beat MAC tags; also reports whether any
// stage still carries a valid tag.
module mac_ctrl_tag_pipe
  import cnn_ctrl_pkg::*;
#(
  parameter int DEPTH = PIPE_LAT_DEF + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TAG_W-1:0] tag_i,
  output logic [TAG_W-1:0] tag_o,
  output logic             any_valid_o
);

  mac_tag_t stage_q [DEPTH];

  // NOTE: this array is a shift register, not a RAM, so every stage is reset;
  // stale tags must never leak out after a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[DEPTH-1];

  // NOTE: the default assignment before the loop keeps this purely
  // combinational; without it a latch would be inferred.
  always_comb begin
    any_valid_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) any_valid_o = any_valid_o | stage_q[i].valid;
  end

endmodule

// File: rtl/mac_sched_ctrl.sv
// Layer scheduler for a MAC array: issues activation/weight beats and
// aligned accumulate/output strobes. Optional MAC_SCHED_PERF_CNT_EN adds
// busy/stall performance counters.
module mac_sched_ctrl
  import cnn_ctrl_pkg::*;
#(
  parameter int PIPE_LAT  = PIPE_LAT_DEF,
  parameter int SCALE_LAT = SCALE_LAT_DEF,
  parameter int ACC_W     = 8,
  parameter int PIX_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [ACC_W-1:0] cfg_acc_num_i,
  input  logic [PIX_W-1:0] cfg_pix_num_i,
  input  logic [15:0]      cfg_scale_i,
  output logic             busy_o,
  output logic             done_o,
  input  logic             act_valid_i,
  output logic             act_ready_o,
  output logic [ACC_W-1:0] wgt_addr_o,
  output logic             wgt_rd_o,
  output logic             mac_data_valid_o,
  output logic             mac_weight_valid_o,
  output logic             mac_acc_en_o,
  output logic             mac_adder_rst_o,
  output logic [15:0]      mac_scale_o,
  output logic [7:0]       mac_acc_num_o,
  output logic             out_valid_o
`ifdef MAC_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]      perf_busy_cyc_o,
  output logic [31:0]      perf_stall_cyc_o
`endif
);

  sched_state_t     state_q;
  logic [ACC_W-1:0] acc_num_q, beat_cnt_q, acc_eff;
  logic [PIX_W-1:0] pix_num_q, pix_cnt_q;
  logic             accept, beat_last, pix_last, tag_busy;
  mac_tag_t         tag_in, tag_out;
  logic [SCALE_LAT:0] out_sr_q;

  assign acc_eff   = (cfg_acc_num_i == '0) ? ACC_W'(1) : cfg_acc_num_i;
  assign accept    = act_valid_i & act_ready_o;
  assign beat_last = (beat_cnt_q == acc_num_q - ACC_W'(1));
  assign pix_last  = (pix_cnt_q == pix_num_q - PIX_W'(1));

  assign wgt_rd_o   = accept;
  assign wgt_addr_o = beat_cnt_q;

  assign tag_in.valid = accept;
  assign tag_in.first = accept & (beat_cnt_q == '0);
  assign tag_in.last  = accept & beat_last;

  // One extra stage on top of PIPE_LAT covers the cycle that registers
  // mac_data_valid_o, so the tag lines up with the product at the adder.
  mac_ctrl_tag_pipe #(.DEPTH(PIPE_LAT + 1)) u_tag_pipe (
    .clk         (clk),
    .rst         (rst),
    .tag_i       (tag_in),
    .tag_o       (tag_out),
    .any_valid_o (tag_busy)
  );

  assign mac_acc_en_o    = tag_out.valid;
  assign mac_adder_rst_o = tag_out.valid & tag_out.first;
  assign out_valid_o     = out_sr_q[SCALE_LAT];

  // Accumulator register plus SCALE_LAT clip/scale stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_sr_q <= '0;
    else     out_sr_q <= (SCALE_LAT+1)'({out_sr_q, tag_out.valid & tag_out.last});
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= ST_IDLE;
      acc_num_q          <= '0;
      pix_num_q          <= '0;
      beat_cnt_q         <= '0;
      pix_cnt_q          <= '0;
      busy_o             <= 1'b0;
      done_o             <= 1'b0;
      act_ready_o        <= 1'b0;
      mac_data_valid_o   <= 1'b0;
      mac_weight_valid_o <= 1'b0;
      mac_scale_o        <= '0;
      mac_acc_num_o      <= '0;
    end else begin
      done_o             <= 1'b0;
      mac_data_valid_o   <= accept;
      mac_weight_valid_o <= accept;
      case (state_q)
        ST_IDLE: if (start_i) begin
          acc_num_q     <= acc_eff;
          pix_num_q     <= cfg_pix_num_i;
          mac_scale_o   <= cfg_scale_i;
          mac_acc_num_o <= 8'(acc_eff);
          beat_cnt_q    <= '0;
          pix_cnt_q     <= '0;
          busy_o        <= 1'b1;
          if (cfg_pix_num_i == '0) begin
            state_q <= ST_DONE;
          end else begin
            state_q     <= ST_RUN;
            act_ready_o <= 1'b1;
          end
        end
        ST_RUN: if (accept) begin
          if (beat_last) begin
            beat_cnt_q <= '0;
            pix_cnt_q  <= pix_cnt_q + PIX_W'(1);
            if (pix_last) begin
              state_q     <= ST_DRAIN;
              act_ready_o <= 1'b0;
            end
          end else begin
            beat_cnt_q <= beat_cnt_q + ACC_W'(1);
          end
        end
        // Wait until the last output word has left the scale stages too.
        ST_DRAIN: if (!tag_busy && out_sr_q == '0) state_q <= ST_DONE;
        ST_DONE: begin
          done_o  <= 1'b1;
          busy_o  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef MAC_SCHED_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy_cyc_o  <= '0;
      perf_stall_cyc_o <= '0;
    end else if (state_q == ST_IDLE && start_i) begin
      perf_busy_cyc_o  <= '0;
      perf_stall_cyc_o <= '0;
    end else begin
      if (busy_o && perf_busy_cyc_o != '1)
        perf_busy_cyc_o <= perf_busy_cyc_o + 32'd1;
      if (state_q == ST_RUN && !act_valid_i && perf_stall_cyc_o != '1)
        perf_stall_cyc_o <= perf_stall_cyc_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_sched_ctrl.sv
// Self-checking bench for mac_sched_ctrl: directed and randomized layers
// against a beat-event reference model.
module tb_mac_sched_ctrl;

  localparam int PL      = 12;
  localparam int SL      = 3;
  localparam int LAT_ACC = PL + 1;
  localparam int LAT_OUT = PL + SL + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  cfg_acc_num_i = '0;
  logic [15:0] cfg_pix_num_i = '0;
  logic [15:0] cfg_scale_i = '0;
  logic        act_valid_i = 1'b0;
  logic        busy_o, done_o, act_ready_o, wgt_rd_o;
  logic [7:0]  wgt_addr_o;
  logic        mac_data_valid_o, mac_weight_valid_o, mac_acc_en_o, mac_adder_rst_o;
  logic [15:0] mac_scale_o;
  logic [7:0]  mac_acc_num_o;
  logic        out_valid_o;

  mac_sched_ctrl #(.PIPE_LAT(PL), .SCALE_LAT(SL), .ACC_W(8), .PIX_W(16)) dut (
    .clk                (clk),
    .rst                (rst),
    .start_i            (start_i),
    .cfg_acc_num_i      (cfg_acc_num_i),
    .cfg_pix_num_i      (cfg_pix_num_i),
    .cfg_scale_i        (cfg_scale_i),
    .busy_o             (busy_o),
    .done_o             (done_o),
    .act_valid_i        (act_valid_i),
    .act_ready_o        (act_ready_o),
    .wgt_addr_o         (wgt_addr_o),
    .wgt_rd_o           (wgt_rd_o),
    .mac_data_valid_o   (mac_data_valid_o),
    .mac_weight_valid_o (mac_weight_valid_o),
    .mac_acc_en_o       (mac_acc_en_o),
    .mac_adder_rst_o    (mac_adder_rst_o),
    .mac_scale_o        (mac_scale_o),
    .mac_acc_num_o      (mac_acc_num_o),
    .out_valid_o        (out_valid_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Accepted beats keyed by acceptance cycle: {valid, first, last}.
  logic [2:0] hist [int];

  bit          m_active = 0, m_run = 0;
  int          m_acc = 1, m_pix = 0, m_beats = 0, m_total = 0;
  int          m_start_cyc = 0, m_last_cyc = -1, m_done_cnt = 0;
  logic [15:0] m_scale = '0;
  logic [7:0]  m_accnum = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [2:0] tag_at(input int c);
    if (hist.exists(c)) return hist[c];
    return 3'b000;
  endfunction

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic cycle(input bit st, input bit av);
    bit         acc_now;
    int         idx;
    logic [2:0] t;
    start_i     = st;
    act_valid_i = av;
    @(negedge clk);
    acc_now = m_run && av;
    check("act_ready", act_ready_o, m_run);
    check("wgt_rd", wgt_rd_o, acc_now);
    if (acc_now) check("wgt_addr", wgt_addr_o, m_beats % m_acc);
    t = tag_at(cyc - 1);
    check("mac_data_valid", mac_data_valid_o, t[2]);
    check("mac_weight_valid", mac_weight_valid_o, t[2]);
    t = tag_at(cyc - LAT_ACC);
    check("mac_acc_en", mac_acc_en_o, t[2]);
    check("mac_adder_rst", mac_adder_rst_o, t[2] & t[1]);
    t = tag_at(cyc - LAT_OUT);
    check("out_valid", out_valid_o, t[2] & t[0]);
    check("mac_scale", mac_scale_o, m_scale);
    check("mac_acc_num", mac_acc_num_o, m_accnum);
    if (m_active && m_pix == 0)
      check("done_o", done_o, cyc == m_start_cyc + 2);
    else if (!(m_active && m_last_cyc >= 0 && cyc > m_last_cyc + LAT_OUT))
      check("done_o", done_o, 1'b0);
    if (!done_o) check("busy", busy_o, m_active && cyc > m_start_cyc);

    if (acc_now) begin
      idx = m_beats % m_acc;
      hist[cyc] = {1'b1, idx == 0, idx == m_acc - 1};
      m_beats++;
      if (m_beats == m_total) begin
        m_run      = 0;
        m_last_cyc = cyc;
      end
    end
    if (done_o && m_active) begin
      m_done_cnt++;
      m_active = 0;
    end else if (st && !m_active) begin
      m_active    = 1;
      m_start_cyc = cyc;
      m_acc       = (cfg_acc_num_i == 0) ? 1 : int'(cfg_acc_num_i);
      m_pix       = int'(cfg_pix_num_i);
      m_total     = m_acc * m_pix;
      m_beats     = 0;
      m_last_cyc  = -1;
      m_done_cnt  = 0;
      m_run       = (m_pix != 0);
      m_scale     = cfg_scale_i;
      m_accnum    = 8'(m_acc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_ready", act_ready_o, 1'b0);
    check("rst_wgt_addr", wgt_addr_o, 8'd0);
    check("rst_wgt_rd", wgt_rd_o, 1'b0);
    check("rst_data_valid", mac_data_valid_o, 1'b0);
    check("rst_weight_valid", mac_weight_valid_o, 1'b0);
    check("rst_acc_en", mac_acc_en_o, 1'b0);
    check("rst_adder_rst", mac_adder_rst_o, 1'b0);
    check("rst_scale", mac_scale_o, 16'd0);
    check("rst_acc_num", mac_acc_num_o, 8'd0);
    check("rst_out_valid", out_valid_o, 1'b0);
    hist.delete();
    m_active = 0;
    m_run    = 0;
    m_scale  = '0;
    m_accnum = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
  endtask

  // mode: 0 always valid, 1 random valid, 2 two-cycle bubble after beat 1,
  // 3 stray start with new cfg after beat 1. rst_after >= 0 resets that many
  // cycles after the last beat.
  task automatic run_layer(input int acc, input int pix, input int scale,
                           input int mode, input int rst_after);
    int n = 0;
    int bub = 0;
    bit av, st, stray_done = 0;
    cfg_acc_num_i = 8'(acc);
    cfg_pix_num_i = 16'(pix);
    cfg_scale_i   = 16'(scale);
    cycle(1'b1, 1'b0);
    while (m_active && n < 500) begin
      if (rst_after >= 0 && m_last_cyc >= 0 && cyc == m_last_cyc + rst_after) begin
        do_reset();
        return;
      end
      st = 1'b0;
      case (mode)
        1: av = ($urandom_range(0, 3) != 0);
        2: begin
          av = !(m_beats == 2 && bub < 2);
          if (!av) bub++;
        end
        3: begin
          av = 1'b1;
          if (m_beats == 2 && !stray_done) begin
            st            = 1'b1;
            stray_done    = 1;
            cfg_acc_num_i = 8'd9;
            cfg_pix_num_i = 16'd7;
            cfg_scale_i   = 16'hBEEF;
          end
        end
        default: av = 1'b1;
      endcase
      cycle(st, av);
      n++;
    end
    check("layer_timeout", m_active, 1'b0);
    check("done_count", m_done_cnt, 1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);

    run_layer(4, 2, 16'h0005, 0, -1);   // back-to-back beats, 2 pixels
    run_layer(3, 1, 16'h0002, 2, -1);   // bubble mid-pixel
    run_layer(5, 0, 16'h0003, 0, -1);   // empty layer
    run_layer(0, 3, 16'h0007, 0, -1);   // acc=0 behaves as 1
    run_layer(4, 2, 16'h0011, 3, -1);   // start during RUN ignored
    run_layer(4, 2, 16'h0021, 0, 5);    // reset while draining
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'($urandom_range(0, 1)));
    run_layer(2, 2, 16'h0042, 0, -1);   // normal run after reset

    for (int k = 0; k < 8; k++)
      run_layer($urandom_range(0, 5), $urandom_range(0, 3), $urandom, 1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
